// File: rtl/bc_sequencer_if.sv
// Handshake, programming and control-word bus between the sequencing logic and bc_sequencer.
// Abort request/indication signals exist only when BC_SEQ_ABORT_EN is defined.
interface bc_sequencer_if #(
  parameter int NUM_STEPS = 6,
  parameter int NUM_LD    = 4,
  parameter int NUM_SEL   = 3,
  parameter int SEL_W     = 2,
  parameter int ITER_W    = 4
);
  localparam int ADDR_W = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1;
  localparam int CW_W   = NUM_LD + NUM_SEL * SEL_W;

  logic                     i_start;
  logic [ADDR_W-1:0]        i_last_step;
  logic [ITER_W-1:0]        i_iter;
  logic                     i_stall;
  logic                     i_prog_we;
  logic [ADDR_W-1:0]        i_prog_addr;
  logic [CW_W-1:0]          i_prog_data;
  logic [NUM_LD-1:0]        o_ld;
  logic [NUM_SEL*SEL_W-1:0] o_sel;
  logic [ADDR_W-1:0]        o_step;
  logic                     o_busy;
  logic                     o_done;
`ifdef BC_SEQ_ABORT_EN
  logic                     i_abort;
  logic                     o_aborted;
`endif

  modport master (
    output i_start, i_last_step, i_iter, i_stall, i_prog_we, i_prog_addr, i_prog_data,
`ifdef BC_SEQ_ABORT_EN
    output i_abort,
    input  o_aborted,
`endif
    input  o_ld, o_sel, o_step, o_busy, o_done
  );

  modport slave (
    input  i_start, i_last_step, i_iter, i_stall, i_prog_we, i_prog_addr, i_prog_data,
`ifdef BC_SEQ_ABORT_EN
    input  i_abort,
    output o_aborted,
`endif
    output o_ld, o_sel, o_step, o_busy, o_done
  );
endinterface

// File: rtl/bc_sequencer.sv
// Programmable control-word sequencer: replays table[0..last_step] for iter passes on ld/sel.
// Define BC_SEQ_ABORT_EN to add the abort input and aborted output.
module bc_sequencer #(
  parameter int NUM_STEPS = 6,
  parameter int NUM_LD    = 4,
  parameter int NUM_SEL   = 3,
  parameter int SEL_W     = 2,
  parameter int ITER_W    = 4
) (
  input logic           clk,
  input logic           reset,
  bc_sequencer_if.slave bus
);
  localparam int ADDR_W = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1;
  localparam int SW_W   = NUM_SEL * SEL_W;
  localparam int CW_W   = NUM_LD + SW_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW_W-1:0]   r_table [NUM_STEPS];
  logic [NUM_LD-1:0] r_ld, w_ld_nxt;
  logic [SW_W-1:0]   r_sel, w_sel_nxt;
  logic [ADDR_W-1:0] r_step, w_step_nxt;
  logic [ADDR_W-1:0] r_last, w_last_nxt;
  logic [ITER_W-1:0] r_iter, w_iter_nxt;
  logic [ITER_W-1:0] r_pass, w_pass_nxt;
  logic              r_busy, r_done;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_fetch_idx;
  logic [CW_W-1:0]   w_word;
  logic              w_abort;

`ifdef BC_SEQ_ABORT_EN
  logic r_aborted;
  assign w_abort       = bus.i_abort;
  assign bus.o_aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  assign w_word = r_table[w_fetch_idx];

  // Next-state and next-output decode for the sequencer FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_nxt    = '0;
    w_sel_nxt   = r_sel;
    w_step_nxt  = r_step;
    w_last_nxt  = r_last;
    w_iter_nxt  = r_iter;
    w_pass_nxt  = r_pass;
    w_fetch     = 1'b0;
    w_fetch_idx = '0;
    case (r_state)
      ST_IDLE: begin
        w_sel_nxt  = '0;
        w_step_nxt = '0;
        if (bus.i_start) begin
          w_state_nxt = ST_RUN;
          w_last_nxt  = (bus.i_last_step > LAST_IDX) ? LAST_IDX : bus.i_last_step;
          w_iter_nxt  = (bus.i_iter == '0) ? ITER_W'(1) : bus.i_iter;
          w_pass_nxt  = '0;
          w_fetch     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          w_state_nxt = ST_DONE;
          w_sel_nxt   = '0;
          w_step_nxt  = '0;
        end else if (bus.i_stall) begin
          // ld drops to zero so each word's loads fire exactly once
          w_state_nxt = ST_RUN;
        end else if (r_step != r_last) begin
          w_fetch     = 1'b1;
          w_fetch_idx = r_step + ADDR_W'(1);
        end else if (ITER_W'(r_pass + ITER_W'(1)) < r_iter) begin
          w_fetch     = 1'b1;
          w_fetch_idx = '0;
          w_pass_nxt  = r_pass + ITER_W'(1);
        end else begin
          w_state_nxt = ST_DONE;
          w_sel_nxt   = '0;
          w_step_nxt  = '0;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = '0;
        w_step_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = '0;
        w_step_nxt  = '0;
      end
    endcase
    if (w_fetch) begin
      w_step_nxt = w_fetch_idx;
      w_ld_nxt   = w_word[NUM_LD-1:0];
      w_sel_nxt  = w_word[CW_W-1:NUM_LD];
    end else begin
      w_step_nxt = w_step_nxt;
    end
  end

  // State, latched run parameters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ld    <= '0;
      r_sel   <= '0;
      r_step  <= '0;
      r_last  <= '0;
      r_iter  <= '0;
      r_pass  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ld    <= w_ld_nxt;
      r_sel   <= w_sel_nxt;
      r_step  <= w_step_nxt;
      r_last  <= w_last_nxt;
      r_iter  <= w_iter_nxt;
      r_pass  <= w_pass_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef BC_SEQ_ABORT_EN
  // Aborted flag accompanies the done pulse of an aborted run only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= (r_state == ST_RUN) && w_abort;
    end
  end
`endif

  // Control-word table; a same-edge fetch still sees the old word, and addresses past the table are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        if (bus.i_prog_we && (bus.i_prog_addr == ADDR_W'(i))) begin
          r_table[i] <= bus.i_prog_data;
        end
      end
    end
  end

  assign bus.o_ld   = r_ld;
  assign bus.o_sel  = r_sel;
  assign bus.o_step = r_step;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
endmodule

// File: doc/bc_sequencer.md
Name: bc_sequencer

Overview:
- Parametrised successor of the fixed six-state control block (BC).
- Replaces hard-coded states with a programmable control-word table of NUM_STEPS entries, and adds a start/busy/done handshake, an iteration count and a stall input.
- Drives the load enables and mux selects of the datapath, one control word per step.
- Sits between the top-level sequencing logic and the datapath registers/muxes.

Parameters:
NUM_STEPS, 6, number of table entries (>=2)
NUM_LD, 4, number of load/enable outputs (default order: ld[0]=LX, ld[1]=LS, ld[2]=LH, ld[3]=H)
NUM_SEL, 3, number of mux selects (default order: M0, M1, M2)
SEL_W, 2, width of each mux select
ITER_W, 4, width of the iteration count
(local) ADDR_W = max(1, clog2(NUM_STEPS)); CW_W = NUM_LD + NUM_SEL*SEL_W

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a run; sampled in IDLE only
last_step  input  ADDR_W  index of the final step per pass; latched at start
iter  input  ITER_W  number of passes; latched at start; 0 treated as 1
stall  input  1  hold the sequence for this cycle
prog_we  input  1  table write enable
prog_addr  input  ADDR_W  table write address
prog_data  input  CW_W  control word: [NUM_LD-1:0]=ld, upper bits=sel (select k at [NUM_LD+k*SEL_W +: SEL_W])
ld  output  NUM_LD  registered load enables
sel  output  NUM_SEL*SEL_W  registered mux selects
step  output  ADDR_W  index of the word currently on ld/sel
busy  output  1  high in RUN
done  output  1  one-cycle pulse at completion

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ld, sel, step, busy, done all 0; every table entry cleared to 0; pass and step counters 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - ld=0, sel=0, busy=0.
  - On an edge with start=1: latch last_step (clamped to NUM_STEPS-1) and iter (0 becomes 1); step<=0; ld/sel<=table[0]; enter RUN. First word appears 1 cycle after start is sampled.
- RUN, edge with stall=0:
  - Not at last_step: step+1, load table[step+1].
  - At last_step with passes remaining: step<=0, load table[0], pass count +1.
  - At last_step of the final pass: ld<=0, sel<=0, step<=0, go to DONE.
- RUN, edge with stall=1: step and sel hold; ld<=0. Each step's ld bits are active for exactly one cycle regardless of stalls. Stall is ignored outside RUN.
- Run length with no stalls: (last_step+1)*iter cycles of busy=1.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start in DONE is ignored.
- start while busy: ignored; latched last_step/iter are unaffected.
- Table writes: allowed in any state.
  - A write and a fetch of the same address on the same edge: the fetch returns the old word.
  - prog_addr >= NUM_STEPS: write dropped.
- Reset asserted mid-run: immediate return to the reset values above, including the cleared table.

Optional Feature:
Macro BC_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1) and output aborted (1).
  - abort=1 on a RUN edge (takes priority over stall) clears ld/sel/step and enters DONE. done pulses with aborted=1 in the same cycle; aborted is 0 otherwise.
  - abort is ignored outside RUN.
- Undefined: ports absent; a run always completes.

Test Plan:
- Program the six legacy words, e.g. step0 ld=4'b1101 sel=6'b00_01_00 … step5 ld=0 sel=0; last_step=5, iter=1, pulse start -> busy=1 for 6 cycles; ld = 1101,1010,1100,0010,0010,0000; step 0..5; then done=1 for 1 cycle, busy=0.
- last_step=1, iter=3 -> 6 RUN cycles; step = 0,1,0,1,0,1; single done pulse after the sixth.
- Same as scenario 1 with stall=1 for 2 cycles while step=2 -> ld=0 and sel held for those cycles; step stays 2; busy lasts 8 cycles; each word's ld is seen once.
- iter=0, last_step=7 with NUM_STEPS=6 -> behaves as iter=1, last_step=5. Second start pulsed at RUN cycle 3 -> ignored; exactly one done pulse.
- reset driven low at RUN step 3, between clock edges -> ld, sel, busy, step go to 0 immediately; after release, start with an unprogrammed table yields ld=0 and sel=0 for every step.
- With BC_SEQ_ABORT_EN: abort at step 2 together with stall=1 -> next cycle done=1, aborted=1, ld=0; IDLE one cycle later. Without the macro: build compiles with no abort/aborted ports.
